rv_decode: RTL and testbench
============================

Name: rv_decode

Overview:
- RV32I decode/operand-fetch stage, directly upstream of rv_alu.
- Accepts instruction words from fetch over a valid/ready handshake.
- Reads a 32x32 register file that it owns; the register file is written by the writeback port.
- Registers the decoded ALU opcode, operands and destination into one pipeline register.
- Presents that register to the ALU over a second valid/ready handshake.
- Supported subset: OP, OP-IMM, LUI, AUIPC. Every other instruction is flagged illegal.

Parameters:
- XLEN, 32, datapath and register width. Only 32 is supported.
- REG_NUM, 32, number of architectural registers.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  kill the in-flight decoded instruction.
- if_valid  in  1  fetch has an instruction.
- if_ready  out  1  decode can accept an instruction this cycle.
- if_instr  in  32  instruction word.
- if_pc  in  32  PC of if_instr.
- wb_we  in  1  register-file write enable.
- wb_rd  in  5  write address.
- wb_data  in  32  write data.
- ex_valid  out  1  decoded instruction is valid.
- ex_ready  in  1  ALU accepts the decoded instruction.
- ex_alu_op  out  4  ALU operation code.
- ex_op_a  out  32  operand A.
- ex_op_b  out  32  operand B.
- ex_rd  out  5  destination register.
- ex_rd_we  out  1  result is to be written back.
- ex_pc  out  32  PC of the decoded instruction.
- ex_illegal  out  1  unsupported or malformed encoding.

Behaviour:
- Reset, synchronous on rst=1 at a clk edge:
  - All ex_* outputs go to 0.
  - All register-file entries are cleared to 0.
  - rst overrides flush, wb_we and any accept.
- if_ready = !ex_valid || ex_ready. This is combinational and has no dependence on if_valid.
- Accept: if_valid && if_ready at a clk edge.
  - Decode is combinational from if_instr and the register-file read.
  - Results are registered; ex_valid=1 on the next cycle. Latency is exactly 1 cycle.
- Hold: ex_valid && !ex_ready. All ex_* outputs stay stable and no new instruction is accepted.
- Drain: if ex_ready is high, ex_valid is high and there is no accept, ex_valid falls next cycle.
- flush=1:
  - ex_valid=0 next cycle.
  - Any instruction accepted in the same cycle is discarded.
  - Register-file writes still occur.
- Register file:
  - Write when wb_we && wb_rd!=0.
  - x0 always reads 0.
  - Same-cycle write and read of the same register: see Optional Feature.
- Operand rules (ex_alu_op: ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9):
  - OP (0110011): op_a=rs1, op_b=rs2, op selected from funct3/funct7.
    - funct7=0x20 is legal only with funct3 000 (SUB) or 101 (SRA).
    - Any other funct7 value is illegal.
  - OP-IMM (0010011): op_a=rs1, op_b=sign-extended imm[31:20].
    - Shifts use op_b = zero-extended instr[24:20].
    - SLLI requires funct7=0. SRLI/SRAI require funct7 0x00 or 0x20.
  - LUI: op_a=0, op_b={instr[31:12],12'b0}, ADD.
  - AUIPC: op_a=if_pc, op_b={instr[31:12],12'b0}, ADD.
  - Legal instruction: ex_rd=instr[11:7], ex_rd_we=1, ex_illegal=0.
  - Illegal instruction (including instr[1:0]!=11):
    - ex_valid=1, ex_illegal=1, ex_rd_we=0.
    - op_a=0, op_b=0, op=ADD.
    - ex_rd=instr[11:7], ex_pc=if_pc.
- No RAW scoreboard. Hazards against the instruction in ALU/writeback are resolved outside this block.

Optional Feature:
- Macro RV_DECODE_BYPASS_EN.
- Defined: a same-cycle write and read of the same non-zero register returns wb_data. This is write-first forwarding on the rs1 and rs2 paths.
- Undefined: the read returns the old register value; the new value is visible from the next cycle.
- x0 reads 0 in both cases.

Decomposition:
- Package rv_pkg:
  - alu_op_t enum (4-bit codes above).
  - Opcode constants OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC.
  - Funct3/funct7 constants.
  - XLEN.
  - Shared with rv_alu.
- Sub-module rv_regfile: 2 combinational read ports, 1 synchronous write port, synchronous reset, optional bypass.

Test Plan:
- Accept 0x00500093 (addi x1,x0,5) with ex_ready=1. Next cycle: ex_valid=1, op=ADD, op_a=0, op_b=5, rd=1, rd_we=1.
- Write x2=0x00000007 while accepting 0x00210133 (add x2,x2,x2) in the same cycle. Expect op_a=op_b=0x7 with RV_DECODE_BYPASS_EN; otherwise 0x0.
- Write x0=0xFFFFFFFF via wb, then decode 0x00000033. Expect op_a=op_b=0.
- Hold ex_ready=0 for 3 cycles after an accept. Expect if_ready=0 and ex_* stable; releasing ex_ready accepts the next instruction in that same cycle.
- Decode 0x0000006F (JAL). Expect ex_illegal=1, rd_we=0. Decode 0x40001093 (slli with funct7=0x20). Expect illegal.
- Assert flush with an instruction pending and a new accept in the same cycle. Expect ex_valid=0 next cycle. Then assert rst mid-hold. Expect all ex_*=0 and x1 reads 0 afterwards.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I decode/ALU definitions: opcodes, function fields, ALU op codes, decode payload.
package rv_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned REG_AW = 5;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_op_t;

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   localparam logic [6:0] F7_BASE = 7'h00;
   localparam logic [6:0] F7_ALT  = 7'h20;

   // Decoded instruction handed to the ALU
   typedef struct packed {
      alu_op_t               alu_op;
      logic [XLEN-1:0]       op_a;
      logic [XLEN-1:0]       op_b;
      logic [REG_AW-1:0]     rd;
      logic                  rd_we;
      logic [XLEN-1:0]       pc;
      logic                  illegal;
   } dec_t;

   // ALU op for funct3 when funct7 selects the base (non-alternate) variant
   function automatic alu_op_t base_op(input logic [2:0] funct3);
      alu_op_t op;
      case (funct3)
         F3_ADD_SUB: op = ALU_ADD;
         F3_SLL:     op = ALU_SLL;
         F3_SLT:     op = ALU_SLT;
         F3_SLTU:    op = ALU_SLTU;
         F3_XOR:     op = ALU_XOR;
         F3_SRL_SRA: op = ALU_SRL;
         F3_OR:      op = ALU_OR;
         default:    op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/rv_regfile.sv
// Architectural register file: two combinational reads, one synchronous write, x0 hardwired to 0.
// RV_DECODE_BYPASS_EN forwards a same-cycle write to the read ports (write-first).
module rv_regfile
   import rv_pkg::*;
#(
   parameter int unsigned REG_NUM = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] rs1,
   input  logic [REG_AW-1:0] rs2,
   output logic [XLEN-1:0]   rs1_data_c,
   output logic [XLEN-1:0]   rs2_data_c,
   input  logic              we,
   input  logic [REG_AW-1:0] wa,
   input  logic [XLEN-1:0]   wd
);

   logic [XLEN-1:0] regs [REG_NUM];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(REG_NUM); i++) regs[i] <= '0;
      end else if (we && (wa != '0)) begin
         regs[wa] <= wd;
      end
   end

   always_comb begin
      rs1_data_c = regs[rs1];
      rs2_data_c = regs[rs2];
`ifdef RV_DECODE_BYPASS_EN
      if (we && (wa == rs1)) rs1_data_c = wd;
      if (we && (wa == rs2)) rs2_data_c = wd;
`else
`endif
      // x0 wins over any forwarded write
      if (rs1 == '0) rs1_data_c = '0;
      if (rs2 == '0) rs2_data_c = '0;
   end

endmodule

// File: rtl/rv_decode.sv
// RV32I decode/operand-fetch stage (OP, OP-IMM, LUI, AUIPC) feeding rv_alu through one pipeline register.
// Build option RV_DECODE_BYPASS_EN enables write-first forwarding in the register file.
module rv_decode
   import rv_pkg::*;
#(
   parameter int unsigned REG_NUM = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              if_valid,
   output logic              if_ready,
   input  logic [31:0]       if_instr,
   input  logic [XLEN-1:0]   if_pc,
   input  logic              wb_we,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [XLEN-1:0]   wb_data,
   output logic              ex_valid,
   input  logic              ex_ready,
   output logic [3:0]        ex_alu_op,
   output logic [XLEN-1:0]   ex_op_a,
   output logic [XLEN-1:0]   ex_op_b,
   output logic [REG_AW-1:0] ex_rd,
   output logic              ex_rd_we,
   output logic [XLEN-1:0]   ex_pc,
   output logic              ex_illegal
);

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_u;
   logic [XLEN-1:0] shamt;
   logic [XLEN-1:0] rs1_data_c;
   logic [XLEN-1:0] rs2_data_c;
   logic            accept;
   dec_t            dec;
   dec_t            ex_q;
   logic            ex_valid_q;

   assign opcode = if_instr[6:0];
   assign funct3 = if_instr[14:12];
   assign funct7 = if_instr[31:25];
   assign imm_i  = {{20{if_instr[31]}}, if_instr[31:20]};
   assign imm_u  = {if_instr[31:12], 12'b0};
   assign shamt  = XLEN'(if_instr[24:20]);

   rv_regfile #(
      .REG_NUM (REG_NUM)
   ) u_regfile (
      .clk        (clk),
      .rst        (rst),
      .rs1        (if_instr[19:15]),
      .rs2        (if_instr[24:20]),
      .rs1_data_c (rs1_data_c),
      .rs2_data_c (rs2_data_c),
      .we         (wb_we),
      .wa         (wb_rd),
      .wd         (wb_data)
   );

   // Combinational decode of the instruction currently offered by fetch
   always_comb begin
      dec         = '0;
      dec.alu_op  = ALU_ADD;
      dec.rd      = if_instr[11:7];
      dec.rd_we   = 1'b1;
      dec.pc      = if_pc;
      dec.illegal = 1'b0;
      case (opcode)
         OPC_OP: begin
            dec.op_a = rs1_data_c;
            dec.op_b = rs2_data_c;
            if (funct7 == F7_BASE)
               dec.alu_op = base_op(funct3);
            else if ((funct7 == F7_ALT) && (funct3 == F3_ADD_SUB))
               dec.alu_op = ALU_SUB;
            else if ((funct7 == F7_ALT) && (funct3 == F3_SRL_SRA))
               dec.alu_op = ALU_SRA;
            else
               dec.illegal = 1'b1;
         end
         OPC_OPIMM: begin
            dec.op_a   = rs1_data_c;
            dec.op_b   = imm_i;
            dec.alu_op = base_op(funct3);
            if (funct3 == F3_SLL) begin
               dec.op_b = shamt;
               if (funct7 != F7_BASE) dec.illegal = 1'b1;
            end else if (funct3 == F3_SRL_SRA) begin
               dec.op_b = shamt;
               if (funct7 == F7_ALT) dec.alu_op = ALU_SRA;
               else if (funct7 != F7_BASE) dec.illegal = 1'b1;
            end
         end
         OPC_LUI: begin
            dec.op_b = imm_u;
         end
         OPC_AUIPC: begin
            dec.op_a = if_pc;
            dec.op_b = imm_u;
         end
         default: dec.illegal = 1'b1;
      endcase
      // Illegal encodings travel as an inert ADD 0,0 with no writeback
      if (dec.illegal) begin
         dec.alu_op = ALU_ADD;
         dec.op_a   = '0;
         dec.op_b   = '0;
         dec.rd_we  = 1'b0;
      end
   end

   assign if_ready = !ex_valid_q || ex_ready;
   assign accept   = if_valid && if_ready;

   // Decode -> ALU pipeline register
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid_q <= 1'b0;
         ex_q       <= '0;
      end else if (flush) begin
         ex_valid_q <= 1'b0;
      end else if (accept) begin
         ex_valid_q <= 1'b1;
         ex_q       <= dec;
      end else if (ex_ready) begin
         ex_valid_q <= 1'b0;
      end
   end

   assign ex_valid   = ex_valid_q;
   assign ex_alu_op  = ex_q.alu_op;
   assign ex_op_a    = ex_q.op_a;
   assign ex_op_b    = ex_q.op_b;
   assign ex_rd      = ex_q.rd;
   assign ex_rd_we   = ex_q.rd_we;
   assign ex_pc      = ex_q.pc;
   assign ex_illegal = ex_q.illegal;

endmodule

// File: tb/tb_rv_decode.sv
// Directed scoreboard bench for rv_decode: expected decodes queued at issue, compared at ALU handoff.
module tb_rv_decode;

   logic        clk = 1'b0;
   logic        rst, flush, if_valid, if_ready, wb_we, ex_valid, ex_ready, ex_rd_we, ex_illegal;
   logic [31:0] if_instr, if_pc, wb_data, ex_op_a, ex_op_b, ex_pc;
   logic [4:0]  wb_rd, ex_rd;
   logic [3:0]  ex_alu_op;

   localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLT = 4'd3, OP_SLTU = 4'd4,
                          OP_XOR = 4'd5, OP_SRA = 4'd7, OP_OR = 4'd8, OP_AND = 4'd9;
`ifdef RV_DECODE_BYPASS_EN
   localparam logic [31:0] BYP7 = 32'h7;
`else
   localparam logic [31:0] BYP7 = 32'h0;
`endif

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic        we;
      logic        ill;
      logic [31:0] pc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   rv_decode dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .if_valid   (if_valid),
      .if_ready   (if_ready),
      .if_instr   (if_instr),
      .if_pc      (if_pc),
      .wb_we      (wb_we),
      .wb_rd      (wb_rd),
      .wb_data    (wb_data),
      .ex_valid   (ex_valid),
      .ex_ready   (ex_ready),
      .ex_alu_op  (ex_alu_op),
      .ex_op_a    (ex_op_a),
      .ex_op_b    (ex_op_b),
      .ex_rd      (ex_rd),
      .ex_rd_we   (ex_rd_we),
      .ex_pc      (ex_pc),
      .ex_illegal (ex_illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Sample at negedge; a valid&&ready handoff pops the scoreboard
   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (ex_valid && ex_ready && !flush) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 32'(ex_pc), 32'hFFFF_FFFF);
         end else begin
            e = sb.pop_front();
            chk("alu_op",  32'(ex_alu_op),  32'(e.op));
            chk("op_a",    ex_op_a,         e.a);
            chk("op_b",    ex_op_b,         e.b);
            chk("rd",      32'(ex_rd),      32'(e.rd));
            chk("rd_we",   32'(ex_rd_we),   32'(e.we));
            chk("illegal", 32'(ex_illegal), 32'(e.ill));
            chk("pc",      ex_pc,           e.pc);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] instr, input logic [31:0] pc, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        input logic we, input logic ill);
      if_valid = 1'b1;
      if_instr = instr;
      if_pc    = pc;
      sb.push_back('{op, a, b, rd, we, ill, pc});
      tick();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"},   32'(ex_valid),   32'h0);
      chk({tag, "_alu_op"},  32'(ex_alu_op),  32'h0);
      chk({tag, "_op_a"},    ex_op_a,         32'h0);
      chk({tag, "_op_b"},    ex_op_b,         32'h0);
      chk({tag, "_rd"},      32'(ex_rd),      32'h0);
      chk({tag, "_rd_we"},   32'(ex_rd_we),   32'h0);
      chk({tag, "_pc"},      ex_pc,           32'h0);
      chk({tag, "_illegal"}, 32'(ex_illegal), 32'h0);
      chk({tag, "_if_ready"}, 32'(if_ready),  32'h1);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0;
      wb_we = 1'b0; wb_rd = '0; wb_data = '0; ex_ready = 1'b1;
      @(posedge clk); #1;
      tick();
      rst = 1'b0;
      chk_zero("reset");

      // x1 = 0x10 for later operand checks
      wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'h10;
      tick();
      wb_we = 1'b0;

      issue(32'h00500093, 32'h100, OP_ADD, 32'h0, 32'h5, 5'd1, 1'b1, 1'b0);
      wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'h7;
      issue(32'h00210133, 32'h104, OP_ADD, BYP7, BYP7, 5'd2, 1'b1, 1'b0);
      wb_we = 1'b0;
      issue(32'h000101B3, 32'h108, OP_ADD, 32'h7, 32'h0, 5'd3, 1'b1, 1'b0);
      wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
      issue(32'h00000033, 32'h10C, OP_ADD, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);
      wb_we = 1'b0;
      issue(32'h00000033, 32'h110, OP_ADD, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);
      issue(32'h40208233, 32'h114, OP_SUB, 32'h10, 32'h7, 5'd4, 1'b1, 1'b0);
      issue(32'h4020D2B3, 32'h118, OP_SRA, 32'h10, 32'h7, 5'd5, 1'b1, 1'b0);
      issue(32'hFFF0A313, 32'h11C, OP_SLT, 32'h10, 32'hFFFF_FFFF, 5'd6, 1'b1, 1'b0);
      issue(32'h4030D393, 32'h120, OP_SRA, 32'h10, 32'h3, 5'd7, 1'b1, 1'b0);
      issue(32'h12345437, 32'h124, OP_ADD, 32'h0, 32'h1234_5000, 5'd8, 1'b1, 1'b0);
      issue(32'hFFFFF497, 32'h200, OP_ADD, 32'h200, 32'hFFFF_F000, 5'd9, 1'b1, 1'b0);
      issue(32'h0020F533, 32'h204, OP_AND, 32'h10, 32'h7, 5'd10, 1'b1, 1'b0);
      issue(32'h0020B5B3, 32'h208, OP_SLTU, 32'h10, 32'h7, 5'd11, 1'b1, 1'b0);
      if_valid = 1'b0;
      tick();
      chk("drain_valid", 32'(ex_valid), 32'h0);

      // Backpressure: xor held three cycles while an or waits at fetch
      ex_ready = 1'b0;
      issue(32'h0020C633, 32'h220, OP_XOR, 32'h10, 32'h7, 5'd12, 1'b1, 1'b0);
      if_valid = 1'b1; if_instr = 32'h0020E6B3; if_pc = 32'h224;
      for (int i = 0; i < 3; i++) begin
         chk("hold_if_ready", 32'(if_ready),  32'h0);
         chk("hold_valid",    32'(ex_valid),  32'h1);
         chk("hold_alu_op",   32'(ex_alu_op), 32'(OP_XOR));
         chk("hold_op_a",     ex_op_a,        32'h10);
         chk("hold_op_b",     ex_op_b,        32'h7);
         chk("hold_pc",       ex_pc,          32'h220);
         tick();
      end
      ex_ready = 1'b1;
      #1;
      chk("release_if_ready", 32'(if_ready), 32'h1);
      sb.push_back('{OP_OR, 32'h10, 32'h7, 5'd13, 1'b1, 1'b0, 32'h224});
      tick();
      if_valid = 1'b0;
      tick();

      // Illegal encodings
      issue(32'h0000006F, 32'h300, OP_ADD, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
      issue(32'h40001093, 32'h304, OP_ADD, 32'h0, 32'h0, 5'd1, 1'b0, 1'b1);
      issue(32'h00500090, 32'h308, OP_ADD, 32'h0, 32'h0, 5'd1, 1'b0, 1'b1);
      issue(32'h40209033, 32'h30C, OP_ADD, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
      issue(32'h0200D093, 32'h310, OP_ADD, 32'h0, 32'h0, 5'd1, 1'b0, 1'b1);
      if_valid = 1'b0;
      tick();

      // Flush kills the pending decode and the one accepted alongside it
      ex_ready = 1'b0;
      if_valid = 1'b1; if_instr = 32'h00500093; if_pc = 32'h400;
      tick();
      chk("preflush_valid", 32'(ex_valid), 32'h1);
      chk("preflush_op_b",  ex_op_b,       32'h5);
      flush = 1'b1; ex_ready = 1'b1; if_instr = 32'h0020F533; if_pc = 32'h404;
      tick();
      flush = 1'b0; if_valid = 1'b0;
      chk("flush_valid", 32'(ex_valid), 32'h0);
      tick();
      chk("flush_valid_after", 32'(ex_valid), 32'h0);

      // Reset in the middle of a hold; a concurrent write must be ignored
      ex_ready = 1'b0;
      if_valid = 1'b1; if_instr = 32'h00500093; if_pc = 32'h500;
      tick();
      if_valid = 1'b0;
      chk("prerst_valid", 32'(ex_valid), 32'h1);
      rst = 1'b1; wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h55;
      tick();
      rst = 1'b0; wb_we = 1'b0;
      chk_zero("midrst");
      ex_ready = 1'b1;
      issue(32'h00108733, 32'h600, OP_ADD, 32'h0, 32'h0, 5'd14, 1'b1, 1'b0);
      issue(32'h000181B3, 32'h604, OP_ADD, 32'h0, 32'h0, 5'd3, 1'b1, 1'b0);
      if_valid = 1'b0;
      tick();
      chk("sb_leftover", 32'(sb.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
